// File: rtl/fir_seq_mac_pkg.sv
// Shared definitions for the sequential FIR MAC: FSM encodings, the MAC side-band
// struct and the default 5-tap coefficient set.
package fir_seq_mac_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  // h[0] sits in the LSBs: {h4,h3,h2,h1,h0} = {1,2,3,2,1}
  localparam logic [39:0] COEF_INIT_5X8 = 40'h01_02_03_02_01;

  typedef struct packed {
    logic vld;
    logic pad;
    logic first;
  } mac_ctl_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_seq_mac_if.sv
// Control, coefficient-load and dual-port memory signals of the sequential FIR MAC.
interface fir_seq_mac_if #(
  parameter int AW  = 10,
  parameter int DW  = 8,
  parameter int CW  = 8,
  parameter int CAW = 3
);
  logic          start;
  logic [AW-1:0] input_addr;
  logic [AW-1:0] output_addr;
  logic [AW-1:0] sample_count;
  logic [4:0]    out_shift;
  logic          busy;
  logic          done;
  logic          coef_we;
  logic [CAW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic [AW-1:0] mem_addr_a;
  logic [DW-1:0] mem_data_out_a;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_data_in_b;
  logic          mem_we_b;

  modport slave (
    input  start, input_addr, output_addr, sample_count, out_shift,
    input  coef_we, coef_addr, coef_data, mem_data_out_a,
    output busy, done, mem_addr_a, mem_addr_b, mem_data_in_b, mem_we_b
  );

  modport master (
    output start, input_addr, output_addr, sample_count, out_shift,
    output coef_we, coef_addr, coef_data, mem_data_out_a,
    input  busy, done, mem_addr_a, mem_addr_b, mem_data_in_b, mem_we_b
  );
endinterface

// File: rtl/fir_seq_mac_round_sat.sv
// Arithmetic right shift with round-half-up, then clamp to the signed DW output range.
module fir_round_sat #(
  parameter int ACCW = 19,
  parameter int DW   = 8
) (
  input  logic signed [ACCW-1:0] acc_i,
  input  logic        [4:0]      shift_i,
  output logic signed [DW-1:0]   y_o
);
  // 32 guard bits keep the rounding constant exact even for shifts beyond ACCW
  localparam int EW = ACCW + 32;
  localparam logic signed [EW-1:0] SMAX = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] round_sat(input logic signed [ACCW-1:0] a,
                                                     input logic [4:0] s);
    logic signed [EW-1:0] one;
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shf;
    logic signed [DW-1:0] res;
    one = {{(EW-1){1'b0}}, 1'b1};
    ext = {{32{a[ACCW-1]}}, a};
    rnd = (s == 5'd0) ? '0 : (one <<< (s - 5'd1));
    shf = (ext + rnd) >>> s;
    if (shf > SMAX)      res = SMAX[DW-1:0];
    else if (shf < SMIN) res = SMIN[DW-1:0];
    else                 res = shf[DW-1:0];
    return res;
  endfunction

  assign y_o = round_sat(acc_i, shift_i);
endmodule

// File: rtl/fir_seq_mac.sv
// Coefficient-programmable FIR over a sample block in shared memory, using one
// time-shared MAC fed one tap per cycle; results are rounded, saturated and written back.
module fir_seq_mac
  import fir_seq_mac_pkg::*;
#(
  parameter int NTAPS = 5,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int AW    = 10,
  parameter logic [NTAPS*CW-1:0] COEF_INIT = COEF_INIT_5X8
) (
  input logic         clk,
  input logic         rst_n,
  fir_seq_mac_if.slave bus
);
  localparam int ACCW = DW + CW + $clog2(NTAPS);
  localparam int CAW  = idx_w(NTAPS);

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [AW-1:0]         in_base_q, in_base_d;
  logic [AW-1:0]         out_base_q, out_base_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [4:0]            shift_q, shift_d;
  logic [AW-1:0]         n_q, n_d;
  logic [CAW-1:0]        k_q, k_d;
  mac_ctl_t              ctl_p1_q, ctl_p1_d;
  logic [CAW-1:0]        tap_p1_q, tap_p1_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [CW-1:0]  coef_q [NTAPS];
  logic signed [CW-1:0]  coef_d [NTAPS];

  logic                    pad_now;
  logic signed [DW-1:0]    x_p1;
  logic signed [DW+CW-1:0] prod_p1;
  logic signed [DW-1:0]    y_rs;

  assign pad_now = (32'(k_q) > 32'(n_q));
  assign x_p1    = signed'(bus.mem_data_out_a);
  assign prod_p1 = x_p1 * coef_q[tap_p1_q];

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    n_d        = n_q;
    k_d        = k_q;
    ctl_p1_d   = '0;
    tap_p1_d   = tap_p1_q;
    acc_d      = acc_q;
    coef_d     = coef_q;

    // Coefficient loads land on the same edge as a start, so a new run sees them
    if ((state_q == ST_IDLE) && bus.coef_we && (32'(bus.coef_addr) < 32'(NTAPS)))
      coef_d[bus.coef_addr] = bus.coef_data;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          in_base_d  = bus.input_addr;
          out_base_d = bus.output_addr;
          cnt_d      = bus.sample_count;
          shift_d    = bus.out_shift;
          n_d        = '0;
          k_d        = '0;
          if (bus.sample_count == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        ctl_p1_d.vld   = 1'b1;
        ctl_p1_d.pad   = pad_now;
        ctl_p1_d.first = (k_q == '0);
        tap_p1_d       = k_q;
        if (k_q == CAW'(NTAPS-1)) begin
          k_d     = '0;
          state_d = ST_FLUSH;
        end else begin
          k_d = k_q + CAW'(1);
        end
      end
      ST_FLUSH: state_d = ST_WRITE;
      default: begin
        if (n_q + AW'(1) == cnt_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          n_d     = n_q + AW'(1);
          state_d = ST_FETCH;
        end
      end
    endcase

    // Stage p1: read data for the tap issued last cycle meets its coefficient
    if (ctl_p1_q.vld)
      acc_d = (ctl_p1_q.first ? '0 : acc_q) + (ctl_p1_q.pad ? '0 : ACCW'(prod_p1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_base_q  <= '0;
      out_base_q <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      n_q        <= '0;
      k_q        <= '0;
      ctl_p1_q   <= '0;
      tap_p1_q   <= '0;
      acc_q      <= '0;
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= COEF_INIT[i*CW +: CW];
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      k_q        <= k_d;
      ctl_p1_q   <= ctl_p1_d;
      tap_p1_q   <= tap_p1_d;
      acc_q      <= acc_d;
      coef_q     <= coef_d;
    end
  end

  fir_round_sat #(.ACCW(ACCW), .DW(DW)) u_round_sat (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .y_o     (y_rs)
  );

  // Padded taps still issue a read, parked at the block base
  assign bus.mem_addr_a    = (state_q == ST_FETCH) ?
                             (pad_now ? in_base_q : in_base_q + n_q - AW'(k_q)) : '0;
  assign bus.mem_addr_b    = (state_q == ST_WRITE) ? out_base_q + n_q : '0;
  assign bus.mem_data_in_b = (state_q == ST_WRITE) ? y_rs : '0;
  assign bus.mem_we_b      = (state_q == ST_WRITE);
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench for fir_seq_mac with a behavioural sync-read sample memory and a result log.
module tb_fir_seq_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_seq_mac_if #(.AW(10), .DW(8), .CW(8), .CAW(3)) bus ();

  fir_seq_mac #(.NTAPS(5), .DW(8), .CW(8), .AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] xmem [0:1023];
  logic [7:0] ymem [0:1023];
  int wr_count = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int c_start = 0;

  always @(posedge clk) begin
    bus.mem_data_out_a <= xmem[bus.mem_addr_a];
    cyc <= cyc + 1;
    if (bus.mem_we_b === 1'b1) begin
      ymem[bus.mem_addr_b] <= bus.mem_data_in_b;
      wr_count <= wr_count + 1;
    end
  end

  task automatic start_run(input logic [9:0] ia, input logic [9:0] oa,
                           input logic [9:0] cnt, input logic [4:0] sh);
    @(negedge clk);
    bus.input_addr = ia;
    bus.output_addr = oa;
    bus.sample_count = cnt;
    bus.out_shift = sh;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    c_start = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.input_addr = '0; bus.output_addr = '0; bus.sample_count = '0; bus.out_shift = '0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
    checks++; if (bus.mem_we_b !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", bus.mem_we_b); end
    checks++; if (bus.mem_addr_a !== 10'd0) begin errors++; $display("FAIL reset_addr_a got %0d want 0", bus.mem_addr_a); end
    checks++; if (bus.mem_addr_b !== 10'd0 || bus.mem_data_in_b !== 8'd0) begin
      errors++; $display("FAIL reset_port_b got %0d/%0d want 0/0", bus.mem_addr_b, bus.mem_data_in_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    logic [7:0] exp [6] = '{8'd16, 8'd32, 8'd48, 8'd32, 8'd16, 8'd0};
    int w0;
    bit ok;
    xmem[0] = 8'd64;
    for (int i = 1; i < 6; i++) xmem[i] = 8'd0;
    w0 = wr_count;
    start_run(10'd0, 10'd100, 10'd6, 5'd2);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL impulse_busy got %0b want 1", bus.busy); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL impulse_timeout got done=%0b want 1", bus.done); end
    checks++; if (cyc - c_start != 42) begin errors++; $display("FAIL impulse_latency got %0d want 42", cyc - c_start); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL impulse_busy_end got %0b want 0", bus.busy); end
    checks++; if (wr_count - w0 != 6) begin errors++; $display("FAIL impulse_writes got %0d want 6", wr_count - w0); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ymem[100+i] !== exp[i]) begin errors++; $display("FAIL impulse_y%0d got %0d want %0d", i, ymem[100+i], exp[i]); end
    end
    repeat (3) @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_sticky got %0b want 1", bus.done); end
  endtask

  task automatic test_step();
    logic [7:0] exp [6] = '{8'd4, 8'd12, 8'd24, 8'd32, 8'd36, 8'd36};
    bit ok;
    for (int i = 0; i < 6; i++) xmem[200+i] = 8'd4;
    start_run(10'd200, 10'd300, 10'd6, 5'd0);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL step_done_clear got %0b want 0", bus.done); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL step_timeout got done=%0b want 1", bus.done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ymem[300+i] !== exp[i]) begin errors++; $display("FAIL step_y%0d got %0d want %0d", i, ymem[300+i], exp[i]); end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int i = 0; i < 5; i++) begin xmem[400+i] = 8'd127; xmem[500+i] = 8'h80; end
    start_run(10'd400, 10'd450, 10'd5, 5'd0);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL satp_timeout got done=%0b want 1", bus.done); end
    checks++; if (ymem[454] !== 8'd127) begin errors++; $display("FAIL satp_y4 got %0d want 127", ymem[454]); end
    checks++; if (ymem[451] !== 8'd127) begin errors++; $display("FAIL satp_y1 got %0d want 127", ymem[451]); end
    start_run(10'd500, 10'd550, 10'd5, 5'd0);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL satn_timeout got done=%0b want 1", bus.done); end
    checks++; if (ymem[554] !== 8'h80) begin errors++; $display("FAIL satn_y4 got %h want 80", ymem[554]); end
    checks++; if (ymem[550] !== 8'h80) begin errors++; $display("FAIL satn_y0 got %h want 80", ymem[550]); end
  endtask

  task automatic test_reprogram();
    logic [2:0] taps [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
    bit ok;
    xmem[600] = 8'd3;
    xmem[601] = 8'hFD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.coef_we = 1'b1; bus.coef_addr = taps[i]; bus.coef_data = (taps[i] == 3'd0) ? 8'd1 : 8'd0;
    end
    // h[1] is cleared on the very edge that accepts start
    @(negedge clk);
    bus.coef_addr = 3'd1; bus.coef_data = 8'd0;
    bus.input_addr = 10'd600; bus.output_addr = 10'd650; bus.sample_count = 10'd2; bus.out_shift = 5'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.coef_we = 1'b0;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reprog_timeout got done=%0b want 1", bus.done); end
    checks++; if (ymem[650] !== 8'd2) begin errors++; $display("FAIL reprog_y0 got %0d want 2", ymem[650]); end
    checks++; if (ymem[651] !== 8'hFF) begin errors++; $display("FAIL reprog_y1 got %h want ff", ymem[651]); end
  endtask

  task automatic test_control();
    int w0;
    bit ok;
    w0 = wr_count;
    start_run(10'd0, 10'd0, 10'd0, 5'd0);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %0b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %0b want 0", bus.busy); end
    repeat (4) @(negedge clk);
    checks++; if (wr_count != w0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_count - w0); end

    xmem[700] = 8'd10;
    xmem[701] = 8'd20;
    w0 = wr_count;
    start_run(10'd700, 10'd750, 10'd2, 5'd0);
    @(negedge clk);
    bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 8'd5;
    @(negedge clk);
    bus.coef_we = 1'b0;
    bus.start = 1'b1; bus.output_addr = 10'd800; bus.sample_count = 10'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout got done=%0b want 1", bus.done); end
    checks++; if (wr_count - w0 != 2) begin errors++; $display("FAIL busy_writes got %0d want 2", wr_count - w0); end
    checks++; if (ymem[750] !== 8'd10) begin errors++; $display("FAIL busy_coef_y0 got %0d want 10", ymem[750]); end
    checks++; if (ymem[751] !== 8'd20) begin errors++; $display("FAIL busy_coef_y1 got %0d want 20", ymem[751]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [6] = '{8'd16, 8'd32, 8'd48, 8'd32, 8'd16, 8'd0};
    int w0;
    bit ok;
    w0 = wr_count;
    start_run(10'd0, 10'd900, 10'd6, 5'd2);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got busy=%0b done=%0b want 0/0", bus.busy, bus.done);
    end
    checks++; if (bus.mem_we_b !== 1'b0 || bus.mem_addr_a !== 10'd0) begin
      errors++; $display("FAIL midrst_mem got we=%0b addr_a=%0d want 0/0", bus.mem_we_b, bus.mem_addr_a);
    end
    repeat (3) @(negedge clk);
    checks++; if (wr_count - w0 != 2) begin errors++; $display("FAIL midrst_writes got %0d want 2", wr_count - w0); end
    rst_n = 1'b1;
    start_run(10'd0, 10'd950, 10'd6, 5'd2);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rerun_timeout got done=%0b want 1", bus.done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ymem[950+i] !== exp[i]) begin errors++; $display("FAIL rerun_y%0d got %0d want %0d", i, ymem[950+i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_saturation();
    test_reprogram();
    test_control();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
